march_engine: RTL and testbench
===============================

MARCH_ENGINE -- requirements
Module: march_engine

Interface
REQ-001 SHALL have parameter ROW_LAST, default 1023, last row address visited.
REQ-002 SHALL have parameter COL_LAST, default 1016, last word column address visited; must be a multiple of 8.
REQ-003 SHALL have ports: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: start  in  1  test request pulse.
REQ-006 SHALL have ports: ce, we  out  1 each  memory enable and write select (1 = write).
REQ-007 SHALL have ports: row_addr, col_addr  out  10 each; bank_addr  out  2  one-hot, 01 = bank0, 10 = bank1.
REQ-008 SHALL have ports: data_gen  out  8  write data; data_o  in  8  registered memory read data.
REQ-009 SHALL have ports: busy, done, pass  out  1 each; fail_valid  out  1  per-fault pulse.
REQ-010 SHALL have ports: fail_row, fail_col  out  10; fail_bank  out  2; fail_syn  out  8  (read XOR expected); fail_cnt  out  16.

Function
REQ-011 SHALL execute March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0). Background 0 = 8'h00, 1 = 8'hFF.
REQ-012 SHALL order addresses for "up" as col fastest in steps of 8 from 0 to COL_LAST, then row 0..ROW_LAST, then bank0 before bank1. "Down" SHALL be the exact reverse order.
REQ-013 SHALL use FSM states IDLE, RUN, DRAIN, DONE. Transitions: start in IDLE/DONE goes to RUN; after the last op of E5, go to DRAIN (1 cycle); then go to DONE.
REQ-014 SHALL drive exactly one memory op per cycle in RUN, back-to-back with no bubbles. E1-E4 SHALL do the read, then the write, at the same address in consecutive cycles. W = number of words = 2*(ROW_LAST+1)*(COL_LAST/8+1); RUN SHALL last 10*W cycles.
REQ-015 SHALL treat memory read latency as 1 cycle: data_o sampled the cycle after a read op. Expected data and address SHALL be pipelined one stage alongside the read.
REQ-016 SHALL, on a mismatch, pulse fail_valid for 1 cycle, with fail_row/col/bank/syn valid in that same cycle. fail_cnt SHALL increment, saturating at 16'hFFFF.
REQ-017 SHALL raise done on the (10*W+2)th rising edge after start is sampled and hold it until the next accepted start. pass SHALL equal (fail_cnt==0) while done is high, and be 0 otherwise.
REQ-018 SHALL hold busy high in RUN and DRAIN only. start while busy SHALL be ignored.
REQ-019 SHALL drive ce=0, we=0, and all address/data outputs 0 outside RUN.
REQ-020 SHALL, on start from DONE, clear fail_cnt, pass and done in the same cycle RUN is entered.

Reset
REQ-021 SHALL, with rst_n low at a clock edge, go to IDLE and zero every output, including fail_cnt and the pipeline valid bit, even mid-RUN. The in-flight compare SHALL be discarded.
REQ-022 SHALL accept start on the first edge after rst_n is released.

Configuration
REQ-023 SHALL support macro MBIST_FIRST_FAIL_EN. When defined, add outputs first_row, first_col (10), first_bank (2), first_syn (8) and first_vld. These capture the first fault after start and hold until the next start or reset.
REQ-024 SHALL, when MBIST_FIRST_FAIL_EN is undefined, omit these ports and their registers entirely. All other behaviour SHALL be unchanged.

Structure
REQ-025 SHALL place the element encoding (E0..E5), FSM state encoding, background constants 8'h00/8'hFF and the bank one-hot codes in shared package mbist_pkg.
REQ-026 SHALL use one sub-module, march_addr_gen: an up/down bank-row-col counter with load, step and last flag, instantiated once.

Verification
REQ-027 SHALL cover: ROW_LAST=1, COL_LAST=8, fault-free memory, start pulse -> W=8, done rises at edge 82, pass=1, fail_cnt=0, no fail_valid.
REQ-028 SHALL cover: default params, bank0 row2 col8 bit7 stuck-at-1 -> exactly 3 fail_valid pulses (E1, E3, E5), each with row 2, col 8, bank 01, syn 8'h80; fail_cnt=3, pass=0.
REQ-029 SHALL cover: ROW_LAST=1, COL_LAST=8, op trace check -> first ops w00@b01 r0 c0, then c8; E3 first op is r@b10 r1 c8; ce never low during RUN.
REQ-030 SHALL cover: rst_n low at cycle 30 of RUN -> next edge IDLE, all outputs 0. A fresh start completes normally with pass=1.
REQ-031 SHALL cover: start re-pulsed at cycle 10 of RUN -> ignored, done still at edge 82. Start in DONE clears done/fail_cnt and reruns.
REQ-032 SHALL cover: MBIST_FIRST_FAIL_EN defined, two faulty cells -> first_* hold the earlier-address fault (first in E1 order); first_vld=1 until the next start.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared encodings for the March C- memory BIST engine: element codes,
// controller state codes, data backgrounds, bank one-hot codes and
// small decode helpers describing each March element.
package mbist_pkg;

    typedef enum logic [2:0] {
        ELEM_E0 = 3'd0,   // up(w0)
        ELEM_E1 = 3'd1,   // up(r0,w1)
        ELEM_E2 = 3'd2,   // up(r1,w0)
        ELEM_E3 = 3'd3,   // down(r0,w1)
        ELEM_E4 = 3'd4,   // down(r1,w0)
        ELEM_E5 = 3'd5    // up(r0)
    } elem_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] BG_ZERO  = 8'h00;
    localparam logic [7:0] BG_ONE   = 8'hFF;
    localparam logic [1:0] BANK0_OH = 2'b01;
    localparam logic [1:0] BANK1_OH = 2'b10;

    // Element walks addresses in descending order.
    function automatic logic elem_is_down(input elem_e e);
        case (e)
            ELEM_E3, ELEM_E4: elem_is_down = 1'b1;
            default:          elem_is_down = 1'b0;
        endcase
    endfunction

    // Element performs a read followed by a write at each address.
    function automatic logic elem_two_op(input elem_e e);
        case (e)
            ELEM_E1, ELEM_E2, ELEM_E3, ELEM_E4: elem_two_op = 1'b1;
            default:                            elem_two_op = 1'b0;
        endcase
    endfunction

    // Background expected by the element's read.
    function automatic logic [7:0] elem_rd_bg(input elem_e e);
        case (e)
            ELEM_E2, ELEM_E4: elem_rd_bg = BG_ONE;
            default:          elem_rd_bg = BG_ZERO;
        endcase
    endfunction

    // Background written by the element's write.
    function automatic logic [7:0] elem_wr_bg(input elem_e e);
        case (e)
            ELEM_E1, ELEM_E3: elem_wr_bg = BG_ONE;
            default:          elem_wr_bg = BG_ZERO;
        endcase
    endfunction

    // Element sequence; E5 wraps back to E0 so the engine parks ready.
    function automatic elem_e elem_next(input elem_e e);
        case (e)
            ELEM_E0: elem_next = ELEM_E1;
            ELEM_E1: elem_next = ELEM_E2;
            ELEM_E2: elem_next = ELEM_E3;
            ELEM_E3: elem_next = ELEM_E4;
            ELEM_E4: elem_next = ELEM_E5;
            default: elem_next = ELEM_E0;
        endcase
    endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Bank/row/column address counter for the March engine. Column is the
// fastest digit (word steps of 8), then row, then bank. Counts up or down,
// can be loaded with the first address of either direction, and flags the
// final address of the current direction.
module march_addr_gen #(
    parameter int ROW_LAST = 1023,
    parameter int COL_LAST = 1016
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       load_down,
    input  logic       step,
    input  logic       down,
    output logic       bank,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic       last
);

    localparam logic [9:0] ROW_LAST_V = 10'(ROW_LAST);
    localparam logic [9:0] COL_LAST_V = 10'(COL_LAST);
    localparam logic [9:0] COL_STEP   = 10'd8;

    logic       bank_r;
    logic [9:0] row_r;
    logic [9:0] col_r;

    // Address counter: load start point, or advance one word in the chosen direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_r <= 1'b0;
            row_r  <= 10'd0;
            col_r  <= 10'd0;
        end else if (load) begin
            if (load_down) begin
                bank_r <= 1'b1;
                row_r  <= ROW_LAST_V;
                col_r  <= COL_LAST_V;
            end else begin
                bank_r <= 1'b0;
                row_r  <= 10'd0;
                col_r  <= 10'd0;
            end
        end else if (step) begin
            if (!down) begin
                if (col_r != COL_LAST_V) begin
                    col_r <= col_r + COL_STEP;
                end else begin
                    col_r <= 10'd0;
                    if (row_r != ROW_LAST_V) begin
                        row_r <= row_r + 10'd1;
                    end else begin
                        row_r  <= 10'd0;
                        bank_r <= ~bank_r;
                    end
                end
            end else begin
                if (col_r != 10'd0) begin
                    col_r <= col_r - COL_STEP;
                end else begin
                    col_r <= COL_LAST_V;
                    if (row_r != 10'd0) begin
                        row_r <= row_r - 10'd1;
                    end else begin
                        row_r  <= ROW_LAST_V;
                        bank_r <= ~bank_r;
                    end
                end
            end
        end else begin
            bank_r <= bank_r;
            row_r  <= row_r;
            col_r  <= col_r;
        end
    end

    // Final address of the sweep in the direction currently selected.
    always_comb begin
        if (down) begin
            last = (bank_r == 1'b0) && (row_r == 10'd0) && (col_r == 10'd0);
        end else begin
            last = (bank_r == 1'b1) && (row_r == ROW_LAST_V) && (col_r == COL_LAST_V);
        end
    end

    assign bank = bank_r;
    assign row  = row_r;
    assign col  = col_r;

endmodule

// File: rtl/march_engine.sv
// March C- memory BIST engine for a two-bank, 8-bit word memory with a
// registered (1-cycle) read port. Issues one memory op per cycle while
// running, compares read data one cycle later, reports each fault and
// summarises with done/pass.
// Optional build macro MBIST_FIRST_FAIL_EN adds first_* outputs that hold
// the first fault seen since the last start.
module march_engine
    import mbist_pkg::*;
#(
    parameter int ROW_LAST = 1023,
    parameter int COL_LAST = 1016
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ce,
    output logic        we,
    output logic [9:0]  row_addr,
    output logic [9:0]  col_addr,
    output logic [1:0]  bank_addr,
    output logic [7:0]  data_gen,
    input  logic [7:0]  data_o,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail_valid,
    output logic [9:0]  fail_row,
    output logic [9:0]  fail_col,
    output logic [1:0]  fail_bank,
    output logic [7:0]  fail_syn,
    output logic [15:0] fail_cnt
`ifdef MBIST_FIRST_FAIL_EN
    ,
    output logic        first_vld,
    output logic [9:0]  first_row,
    output logic [9:0]  first_col,
    output logic [1:0]  first_bank,
    output logic [7:0]  first_syn
`endif
);

    state_e      state_r;
    elem_e       elem_r;
    logic        phase_r;      // 0 = read (or lone op), 1 = write of a read/write pair
    logic        fin_r;        // every op of E5 has been issued
    logic [7:0]  exp_r;        // expected data for the op on the outputs

    logic        pipe_vld_r;   // data_o in this cycle belongs to a read
    logic [7:0]  pipe_exp_r;
    logic [9:0]  pipe_row_r;
    logic [9:0]  pipe_col_r;
    logic [1:0]  pipe_bank_r;

    logic        ag_bank_s;
    logic [9:0]  ag_row_s;
    logic [9:0]  ag_col_s;
    logic        ag_last_s;
    logic        ag_load_s;
    logic        ag_load_down_s;
    logic        ag_step_s;

    logic        start_acc_s;
    logic        issue_s;
    logic        two_op_s;
    logic        elem_end_s;
    logic        op_we_s;
    logic [7:0]  op_wdata_s;
    logic [7:0]  op_exp_s;
    logic        mism_s;
    logic [7:0]  syn_s;
    logic [15:0] fail_cnt_nxt_s;

    march_addr_gen #(
        .ROW_LAST (ROW_LAST),
        .COL_LAST (COL_LAST)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load_s),
        .load_down (ag_load_down_s),
        .step      (ag_step_s),
        .down      (elem_is_down(elem_r)),
        .bank      (ag_bank_s),
        .row       (ag_row_s),
        .col       (ag_col_s),
        .last      (ag_last_s)
    );

    // Decode the op that would be issued this cycle and how the sequencer advances.
    always_comb begin
        start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        issue_s     = start_acc_s || ((state_r == ST_RUN) && !fin_r);
        two_op_s    = elem_two_op(elem_r);
        elem_end_s  = ag_last_s && (!two_op_s || phase_r);
        op_we_s     = (elem_r == ELEM_E0) || (two_op_s && phase_r);
        op_wdata_s  = elem_wr_bg(elem_r);
        op_exp_s    = elem_rd_bg(elem_r);
        if (issue_s) begin
            ag_load_s      = elem_end_s;
            ag_load_down_s = elem_end_s && elem_is_down(elem_next(elem_r));
            ag_step_s      = !elem_end_s && (!two_op_s || phase_r);
        end else begin
            // Park the counter at the first up address while not sweeping.
            ag_load_s      = 1'b1;
            ag_load_down_s = 1'b0;
            ag_step_s      = 1'b0;
        end
    end

    // Compare registered read data against the expected value travelling with it.
    always_comb begin
        syn_s  = data_o ^ pipe_exp_r;
        mism_s = pipe_vld_r && (syn_s != 8'h00);
        if (start_acc_s) begin
            fail_cnt_nxt_s = 16'h0000;
        end else if (mism_s && (fail_cnt != 16'hFFFF)) begin
            fail_cnt_nxt_s = fail_cnt + 16'h0001;
        end else begin
            fail_cnt_nxt_s = fail_cnt;
        end
    end

    // Controller FSM with registered memory-op, compare-pipeline and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            elem_r      <= ELEM_E0;
            phase_r     <= 1'b0;
            fin_r       <= 1'b0;
            exp_r       <= 8'h00;
            ce          <= 1'b0;
            we          <= 1'b0;
            row_addr    <= 10'd0;
            col_addr    <= 10'd0;
            bank_addr   <= 2'b00;
            data_gen    <= 8'h00;
            pipe_vld_r  <= 1'b0;
            pipe_exp_r  <= 8'h00;
            pipe_row_r  <= 10'd0;
            pipe_col_r  <= 10'd0;
            pipe_bank_r <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_valid  <= 1'b0;
            fail_row    <= 10'd0;
            fail_col    <= 10'd0;
            fail_bank   <= 2'b00;
            fail_syn    <= 8'h00;
            fail_cnt    <= 16'h0000;
        end else begin
            if (issue_s) begin
                ce        <= 1'b1;
                we        <= op_we_s;
                row_addr  <= ag_row_s;
                col_addr  <= ag_col_s;
                bank_addr <= ag_bank_s ? BANK1_OH : BANK0_OH;
                data_gen  <= op_we_s ? op_wdata_s : 8'h00;
                exp_r     <= op_exp_s;
                if (elem_end_s) begin
                    phase_r <= 1'b0;
                    elem_r  <= elem_next(elem_r);
                    fin_r   <= (elem_r == ELEM_E5);
                end else begin
                    phase_r <= two_op_s ? ~phase_r : 1'b0;
                end
            end else begin
                ce        <= 1'b0;
                we        <= 1'b0;
                row_addr  <= 10'd0;
                col_addr  <= 10'd0;
                bank_addr <= 2'b00;
                data_gen  <= 8'h00;
                exp_r     <= 8'h00;
            end

            // The read on the outputs now returns data next cycle.
            pipe_vld_r  <= ce && !we;
            pipe_exp_r  <= exp_r;
            pipe_row_r  <= row_addr;
            pipe_col_r  <= col_addr;
            pipe_bank_r <= bank_addr;

            fail_valid <= mism_s;
            if (mism_s) begin
                fail_row  <= pipe_row_r;
                fail_col  <= pipe_col_r;
                fail_bank <= pipe_bank_r;
                fail_syn  <= syn_s;
            end else begin
                fail_row  <= fail_row;
                fail_col  <= fail_col;
                fail_bank <= fail_bank;
                fail_syn  <= fail_syn;
            end
            fail_cnt <= fail_cnt_nxt_s;

            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        fin_r   <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (fin_r) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // Last read's compare resolves on this edge; fold it into pass.
                    state_r <= ST_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= (fail_cnt_nxt_s == 16'h0000);
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MBIST_FIRST_FAIL_EN
    // Capture the first fault after start and hold it until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_vld  <= 1'b0;
            first_row  <= 10'd0;
            first_col  <= 10'd0;
            first_bank <= 2'b00;
            first_syn  <= 8'h00;
        end else if (start_acc_s) begin
            first_vld  <= 1'b0;
            first_row  <= 10'd0;
            first_col  <= 10'd0;
            first_bank <= 2'b00;
            first_syn  <= 8'h00;
        end else if (mism_s && !first_vld) begin
            first_vld  <= 1'b1;
            first_row  <= pipe_row_r;
            first_col  <= pipe_col_r;
            first_bank <= pipe_bank_r;
            first_syn  <= syn_s;
        end else begin
            first_vld  <= first_vld;
            first_row  <= first_row;
            first_col  <= first_col;
            first_bank <= first_bank;
            first_syn  <= first_syn;
        end
    end
`endif

endmodule

// File: tb/tb_march_engine.sv
// Scoreboard bench for march_engine on a small 2-bank x 2-row x 2-word array.
// A behavioural March C- model predicts the op trace and the fault reports
// for a memory with stuck-at bits; a monitor pops and compares as the DUT
// presents ops and fail pulses.
module tb_march_engine;

    localparam int RL = 1;
    localparam int CL = 8;
    localparam int NR = RL + 1;
    localparam int NC = CL / 8 + 1;
    localparam int W  = 2 * NR * NC;
    localparam int DONE_EDGE = 10 * W + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ce, we;
    logic [9:0]  row_addr, col_addr;
    logic [1:0]  bank_addr;
    logic [7:0]  data_gen;
    logic [7:0]  data_o = 8'h00;
    logic        busy, done, pass, fail_valid;
    logic [9:0]  fail_row, fail_col;
    logic [1:0]  fail_bank;
    logic [7:0]  fail_syn;
    logic [15:0] fail_cnt;
`ifdef MBIST_FIRST_FAIL_EN
    logic        first_vld;
    logic [9:0]  first_row, first_col;
    logic [1:0]  first_bank;
    logic [7:0]  first_syn;
`endif

    always #5 clk = ~clk;

    march_engine #(.ROW_LAST(RL), .COL_LAST(CL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ce(ce), .we(we), .row_addr(row_addr), .col_addr(col_addr),
        .bank_addr(bank_addr), .data_gen(data_gen), .data_o(data_o),
        .busy(busy), .done(done), .pass(pass), .fail_valid(fail_valid),
        .fail_row(fail_row), .fail_col(fail_col), .fail_bank(fail_bank),
        .fail_syn(fail_syn), .fail_cnt(fail_cnt)
`ifdef MBIST_FIRST_FAIL_EN
        , .first_vld(first_vld), .first_row(first_row), .first_col(first_col),
        .first_bank(first_bank), .first_syn(first_syn)
`endif
    );

    typedef struct packed {
        logic       we;
        logic [1:0] bank;
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] data;
    } op_t;

    typedef struct packed {
        logic [1:0] bank;
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] syn;
    } fl_t;

    op_t op_q[$];
    fl_t fl_q[$];
    op_t mon_o;
    fl_t mon_f;
    int  ncmp = 0;
    int  nerr = 0;
    bit  mon_en = 1'b0;

    logic [7:0] pmem [W];
    logic [7:0] sa1  [W];
    logic [7:0] sa0  [W];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word index in ascending sweep order: bank, then row, then column.
    function automatic int addr_idx(input logic [1:0] b, input logic [9:0] r, input logic [9:0] c);
        int bi;
        if (b == 2'b01) bi = 0;
        else if (b == 2'b10) bi = 1;
        else return -1;
        if (int'(r) >= NR || c[2:0] != 3'd0 || int'(c) / 8 >= NC) return -1;
        return (bi * NR + int'(r)) * NC + int'(c) / 8;
    endfunction

    function automatic op_t mk_op(input logic w, input int idx, input logic [7:0] d);
        op_t o;
        o.we   = w;
        o.bank = (idx / (NR * NC) == 1) ? 2'b10 : 2'b01;
        o.row  = 10'((idx / NC) % NR);
        o.col  = 10'((idx % NC) * 8);
        o.data = d;
        return o;
    endfunction

    // Memory with a registered read port and stuck-at bits on selected words.
    always @(posedge clk) begin
        int ix;
        if (ce === 1'b1) begin
            ix = addr_idx(bank_addr, row_addr, col_addr);
            if (ix >= 0) begin
                if (we) pmem[ix] <= data_gen;
                else    data_o   <= (pmem[ix] | sa1[ix]) & ~sa0[ix];
            end
        end
    end

    // Reference March C-: fill the op and fault queues for one full run.
    task automatic model_run(output int nf, output fl_t first);
        logic [7:0] m [W];
        logic [7:0] rbg, act;
        int idx;
        fl_t f;
        nf = 0;
        first = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < W; i++) begin
                idx = (e == 3 || e == 4) ? (W - 1 - i) : i;
                if (e == 0) begin
                    op_q.push_back(mk_op(1'b1, idx, 8'h00));
                    m[idx] = 8'h00;
                end else begin
                    rbg = (e == 2 || e == 4) ? 8'hFF : 8'h00;
                    op_q.push_back(mk_op(1'b0, idx, 8'h00));
                    act = (m[idx] | sa1[idx]) & ~sa0[idx];
                    if (act != rbg) begin
                        f.bank = mk_op(1'b0, idx, 8'h00).bank;
                        f.row  = mk_op(1'b0, idx, 8'h00).row;
                        f.col  = mk_op(1'b0, idx, 8'h00).col;
                        f.syn  = act ^ rbg;
                        fl_q.push_back(f);
                        if (nf == 0) first = f;
                        nf++;
                    end
                    if (e < 5) begin
                        op_q.push_back(mk_op(1'b1, idx, ~rbg));
                        m[idx] = ~rbg;
                    end
                end
            end
        end
    endtask

    // Monitor: pop and compare each presented op and each fault pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy && op_q.size() > 0) chk("ce_in_run", ce, 1'b1);
            if (ce) begin
                if (op_q.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL op_unexpected: actual we=%0b b=%0h r=%0d c=%0d required none at %0t",
                             we, bank_addr, row_addr, col_addr, $time);
                end else begin
                    mon_o = op_q.pop_front();
                    chk("op_we", we, mon_o.we);
                    chk("op_bank", bank_addr, mon_o.bank);
                    chk("op_row", row_addr, mon_o.row);
                    chk("op_col", col_addr, mon_o.col);
                    if (mon_o.we) chk("op_wdata", data_gen, mon_o.data);
                end
            end
            if (!busy) chk("idle_outputs", {ce, we, bank_addr, row_addr, col_addr, data_gen}, 64'd0);
            if (fail_valid) begin
                if (fl_q.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL fail_unexpected: actual b=%0h r=%0d c=%0d syn=%0h required none at %0t",
                             fail_bank, fail_row, fail_col, fail_syn, $time);
                end else begin
                    mon_f = fl_q.pop_front();
                    chk("fail_bank", fail_bank, mon_f.bank);
                    chk("fail_row", fail_row, mon_f.row);
                    chk("fail_col", fail_col, mon_f.col);
                    chk("fail_syn", fail_syn, mon_f.syn);
                end
            end
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < W; i++) begin
            sa1[i] = 8'h00;
            sa0[i] = 8'h00;
        end
    endtask

    // One full test run; dir_cnt >= 0 also pins fail_cnt to a fixed figure.
    task automatic run_test(input bit release_rst, input bit repulse, input int dir_cnt);
        int  nf;
        int  n;
        fl_t ff;
        @(posedge clk); #2;
        if (release_rst) rst_n = 1'b1;
        start = 1'b1;
        model_run(nf, ff);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_done_clr", done, 1'b0);
        chk("start_pass_clr", pass, 1'b0);
        chk("start_cnt_clr", fail_cnt, 16'd0);
        n = 1;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (repulse) start = (n == 10);
            if (done !== 1'b1 && n < DONE_EDGE) chk("busy_hold", busy, 1'b1);
        end
        start = 1'b0;
        chk("done_edge", n, DONE_EDGE);
        chk("done_busy", busy, 1'b0);
        chk("pass", pass, (nf == 0));
        chk("fail_cnt", fail_cnt, nf);
        if (dir_cnt >= 0) chk("fail_cnt_dir", fail_cnt, dir_cnt);
        repeat (2) @(posedge clk);
        #1;
        chk("done_held", done, 1'b1);
        chk("opq_drained", op_q.size(), 0);
        chk("failq_drained", fl_q.size(), 0);
`ifdef MBIST_FIRST_FAIL_EN
        chk("first_vld", first_vld, (nf != 0));
        if (nf != 0) chk("first_cell", {first_bank, first_row, first_col, first_syn}, ff);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {ce, we, busy, done, pass, fail_valid, fail_cnt, row_addr, col_addr, bank_addr}, 64'd0);
        chk("reset_fail_fields", {fail_row, fail_col, fail_bank, fail_syn, data_gen}, 64'd0);
        mon_en = 1'b1;

        // Start on the first edge after reset release, fault-free.
        run_test(1'b1, 1'b0, 0);

        // Stuck-at-1 on bit 7 of bank0 row1 col8: seen by E1, E3, E5 reads.
        sa1[addr_idx(2'b01, 10'd1, 10'd8)] = 8'h80;
        run_test(1'b0, 1'b0, 3);

        // Restart from DONE with a start re-pulse mid-run that must be ignored.
        clear_faults();
        run_test(1'b0, 1'b1, 0);

        // Reset at cycle 30 of RUN, with a read mismatch in flight.
        sa1[0] = 8'h01;
        sa0[2] = 8'h08;
        @(posedge clk); #2;
        start = 1'b1;
        begin
            int nf_d;
            fl_t ff_d;
            model_run(nf_d, ff_d);
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("pre_reset_cnt", fail_cnt, 16'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        op_q.delete();
        fl_q.delete();
        chk("midrun_reset", {ce, we, busy, done, pass, fail_valid, fail_cnt, row_addr, col_addr, bank_addr}, 64'd0);
        chk("midrun_reset_data", data_gen, 8'h00);
        @(posedge clk); #1;
        chk("reset_no_late_fail", fail_valid, 1'b0);
        clear_faults();
        run_test(1'b1, 1'b0, 0);

        // Randomised stuck-at faults.
        for (int k = 0; k < 8; k++) begin
            clear_faults();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                int ix;
                logic [7:0] bm;
                ix = int'($urandom_range(0, W - 1));
                bm = 8'h01 << $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) sa1[ix] = sa1[ix] | bm;
                else                           sa0[ix] = sa0[ix] | bm;
            end
            repeat ($urandom_range(0, 4)) @(posedge clk);
            run_test(1'b0, ($urandom_range(0, 3) == 0), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
